// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for uart_rx: the serial line in, and the
// parallel word, strobe and status flags out.
interface uart_rx_if #(
  parameter int NUM_DATA_BITS = 8
);
  logic                     i_rx;
  logic [NUM_DATA_BITS-1:0] o_rxByte;
  logic                     o_rxDoneStrobe;
  logic                     o_rxActive;
  logic                     o_errorFlag;

  // Line side: drives the serial input and consumes the received words.
  modport master (
    output i_rx,
    input  o_rxByte, o_rxDoneStrobe, o_rxActive, o_errorFlag
  );

  // Receiver side: samples the serial input and produces the words.
  modport slave (
    input  i_rx,
    output o_rxByte, o_rxDoneStrobe, o_rxActive, o_errorFlag
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver (start bit, NUM_DATA_BITS data bits LSB first, one stop bit).
// Synchronises the asynchronous line, validates the start bit at mid-bit,
// samples data at mid-bit, checks the stop bit, and publishes whole words only.
module uart_rx #(
  parameter int CLKS_PER_BIT  = 217,
  parameter int NUM_DATA_BITS = 8
) (
  input  logic     i_clk,
  input  logic     i_resetN,
  uart_rx_if.slave bus
);

  localparam logic [15:0] HALF     = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_IDX = 4'(NUM_DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic                     rx_meta_q;
  logic                     rx_sync_q;
  state_t                   state_q;
  logic [15:0]              cnt_q;
  logic [3:0]               bit_idx_q;
  logic [NUM_DATA_BITS-1:0] shift_q;
  logic [NUM_DATA_BITS-1:0] shift_d;
  logic [NUM_DATA_BITS-1:0] rx_byte_q;
  logic                     strobe_q;
  logic                     active_q;
  logic                     error_q;

  // Two-flop synchroniser; resets to the idle (high) line level so reset
  // release never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      // NOTE: non-blocking so rx_sync_q takes the old rx_meta_q, giving two real flop stages.
      rx_meta_q <= bus.i_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // New bit enters at the top and earlier bits move down, so after the last
  // data bit the first-received bit sits in bit 0 (LSB first).
  assign shift_d = NUM_DATA_BITS'({rx_sync_q, shift_q} >> 1);

  // Frame state machine with registered outputs.
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      // NOTE: the shift register is reset too; it is small and this keeps simulation free of X.
      shift_q   <= '0;
      rx_byte_q <= '0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_sync_q) begin
            state_q  <= S_START;
            active_q <= 1'b1;
          end
        end

        S_START: begin
          if (cnt_q == HALF) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            if (!rx_sync_q) begin
              state_q <= S_DATA;
            end else begin
              // Line returned high before mid-bit: a glitch, not a frame.
              state_q  <= S_IDLE;
              active_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        S_DATA: begin
          if (cnt_q == BIT_END) begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            if (bit_idx_q == LAST_IDX) begin
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        S_STOP: begin
          if (cnt_q == BIT_END) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            if (rx_sync_q) begin
              rx_byte_q <= shift_q;
              strobe_q  <= 1'b1;
              state_q   <= S_IDLE;
            end else begin
              // Framing error: keep the last good word, flag it, and wait
              // for the line to go high so a break cannot retrigger.
              error_q <= 1'b1;
              state_q <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        S_BREAK: begin
          if (rx_sync_q) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q  <= S_IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_rxByte       = rx_byte_q;
  assign bus.o_rxDoneStrobe = strobe_q;
  assign bus.o_rxActive     = active_q;
  assign bus.o_errorFlag    = error_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 217 clocks/bit, 8 data bits.
module tb_uart_rx;

  localparam int CPB = 217;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  uart_rx_if #(.NUM_DATA_BITS(8)) rx_if ();

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .NUM_DATA_BITS(8)
  ) dut (
    .i_clk   (clk),
    .i_resetN(rst_n),
    .bus     (rx_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor: counts strobes, logs the word seen with each, and counts
  // strobes that lasted longer than one cycle.
  int         strobe_cnt  = 0;
  int         strobe_long = 0;
  logic       strobe_prev = 1'b0;
  logic [7:0] got_bytes[$];

  always @(negedge clk) begin
    if (rx_if.o_rxDoneStrobe === 1'b1) begin
      strobe_cnt++;
      got_bytes.push_back(rx_if.o_rxByte);
      if (strobe_prev) strobe_long++;
    end
    strobe_prev = rx_if.o_rxDoneStrobe;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start bit plus eight data bits, LSB first, each cpb cycles long.
  task automatic send_start_data(input logic [7:0] data, input int cpb);
    rx_if.i_rx = 1'b0;
    wait_cycles(cpb);
    for (int i = 0; i < 8; i++) begin
      rx_if.i_rx = data[i];
      wait_cycles(cpb);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input int cpb);
    send_start_data(data, cpb);
    rx_if.i_rx = 1'b1;
    wait_cycles(cpb);
  endtask

  task automatic test_reset;
    rx_if.i_rx = 1'b1;
    rst_n = 1'b0;
    wait_cycles(5);
    checks++;
    if ({rx_if.o_rxByte, rx_if.o_rxDoneStrobe, rx_if.o_rxActive, rx_if.o_errorFlag} !== 11'h000) begin
      failures++;
      $display("FAIL reset_state: byte=%h strobe=%b active=%b err=%b, required all 0",
               rx_if.o_rxByte, rx_if.o_rxDoneStrobe, rx_if.o_rxActive, rx_if.o_errorFlag);
    end
    rst_n = 1'b1;
    wait_cycles(10);
    checks++;
    if (rx_if.o_rxActive !== 1'b0 || strobe_cnt !== 0) begin
      failures++;
      $display("FAIL idle_after_reset: active=%b strobes=%0d, required 0/0", rx_if.o_rxActive, strobe_cnt);
    end
  endtask

  task automatic test_basic_frame;
    int base = strobe_cnt;
    send_frame(8'hA5, CPB);
    wait_cycles(30);
    checks++;
    if (strobe_cnt - base !== 1) begin
      failures++;
      $display("FAIL basic_strobe_count: got %0d, required 1", strobe_cnt - base);
    end
    checks++;
    if (rx_if.o_rxByte !== 8'hA5) begin
      failures++;
      $display("FAIL basic_byte: got %h, required a5", rx_if.o_rxByte);
    end
    checks++;
    if (rx_if.o_errorFlag !== 1'b0 || rx_if.o_rxActive !== 1'b0) begin
      failures++;
      $display("FAIL basic_flags: err=%b active=%b, required 0/0", rx_if.o_errorFlag, rx_if.o_rxActive);
    end
    checks++;
    if (strobe_long !== 0) begin
      failures++;
      $display("FAIL basic_strobe_width: %0d multi-cycle strobes, required 0", strobe_long);
    end
  endtask

  task automatic test_glitch;
    int base = strobe_cnt;
    rx_if.i_rx = 1'b0;
    wait_cycles(30);
    checks++;
    if (rx_if.o_rxActive !== 1'b1) begin
      failures++;
      $display("FAIL glitch_active_high: got %b, required 1", rx_if.o_rxActive);
    end
    wait_cycles(20);
    rx_if.i_rx = 1'b1;
    wait_cycles(100);
    checks++;
    if (rx_if.o_rxActive !== 1'b0) begin
      failures++;
      $display("FAIL glitch_active_low: got %b, required 0", rx_if.o_rxActive);
    end
    checks++;
    if (strobe_cnt !== base || rx_if.o_errorFlag !== 1'b0 || rx_if.o_rxByte !== 8'hA5) begin
      failures++;
      $display("FAIL glitch_no_effect: strobes=%0d err=%b byte=%h, required %0d/0/a5",
               strobe_cnt, rx_if.o_errorFlag, rx_if.o_rxByte, base);
    end
    wait_cycles(CPB);
  endtask

  task automatic test_framing_error;
    int base = strobe_cnt;
    send_start_data(8'h3C, CPB);
    rx_if.i_rx = 1'b0;
    wait_cycles(1000);
    checks++;
    if (rx_if.o_rxActive !== 1'b0) begin
      failures++;
      $display("FAIL break_not_active: active=%b, required 0", rx_if.o_rxActive);
    end
    rx_if.i_rx = 1'b1;
    wait_cycles(20);
    checks++;
    if (strobe_cnt !== base || rx_if.o_errorFlag !== 1'b1 || rx_if.o_rxByte !== 8'hA5) begin
      failures++;
      $display("FAIL framing_error: strobes=%0d err=%b byte=%h, required %0d/1/a5",
               strobe_cnt, rx_if.o_errorFlag, rx_if.o_rxByte, base);
    end
    send_frame(8'h81, CPB);
    wait_cycles(30);
    checks++;
    if (strobe_cnt - base !== 1 || rx_if.o_rxByte !== 8'h81 || rx_if.o_errorFlag !== 1'b1) begin
      failures++;
      $display("FAIL after_error_frame: strobes=%0d byte=%h err=%b, required 1/81/1",
               strobe_cnt - base, rx_if.o_rxByte, rx_if.o_errorFlag);
    end
  endtask

  task automatic test_midframe_reset;
    int base;
    logic [7:0] data = 8'h5A;
    rx_if.i_rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 3; i++) begin
      rx_if.i_rx = data[i];
      wait_cycles(CPB);
    end
    rx_if.i_rx = data[3];
    wait_cycles(100);
    checks++;
    if (rx_if.o_rxActive !== 1'b1) begin
      failures++;
      $display("FAIL midframe_active: got %b, required 1", rx_if.o_rxActive);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_if.o_rxByte, rx_if.o_rxDoneStrobe, rx_if.o_rxActive, rx_if.o_errorFlag} !== 11'h000) begin
      failures++;
      $display("FAIL async_reset: byte=%h strobe=%b active=%b err=%b, required all 0",
               rx_if.o_rxByte, rx_if.o_rxDoneStrobe, rx_if.o_rxActive, rx_if.o_errorFlag);
    end
    wait_cycles(5);
    rx_if.i_rx = 1'b1;
    rst_n = 1'b1;
    wait_cycles(20);
    base = strobe_cnt;
    send_frame(8'h55, CPB);
    wait_cycles(30);
    checks++;
    if (strobe_cnt - base !== 1 || rx_if.o_rxByte !== 8'h55) begin
      failures++;
      $display("FAIL after_reset_frame: strobes=%0d byte=%h, required 1/55", strobe_cnt - base, rx_if.o_rxByte);
    end
  endtask

  task automatic test_back_to_back;
    int base = strobe_cnt;
    int qb   = got_bytes.size();
    send_frame(8'h00, CPB);
    send_frame(8'hFF, CPB);
    wait_cycles(30);
    checks++;
    if (strobe_cnt - base !== 2) begin
      failures++;
      $display("FAIL b2b_count: got %0d strobes, required 2", strobe_cnt - base);
    end else begin
      checks++;
      if (got_bytes[qb] !== 8'h00 || got_bytes[qb+1] !== 8'hFF) begin
        failures++;
        $display("FAIL b2b_order: got %h,%h, required 00,ff", got_bytes[qb], got_bytes[qb+1]);
      end
    end
    checks++;
    if (rx_if.o_errorFlag !== 1'b0) begin
      failures++;
      $display("FAIL b2b_error: err=%b, required 0", rx_if.o_errorFlag);
    end
  endtask

  task automatic test_baud_tolerance;
    int rates[2] = '{211, 223};
    foreach (rates[r]) begin
      int base = strobe_cnt;
      rx_if.i_rx = 1'b1;
      wait_cycles(10);
      send_frame(8'hC3, rates[r]);
      wait_cycles(30);
      checks++;
      if (strobe_cnt - base !== 1 || rx_if.o_rxByte !== 8'hC3 || rx_if.o_errorFlag !== 1'b0) begin
        failures++;
        $display("FAIL baud_%0d: strobes=%0d byte=%h err=%b, required 1/c3/0",
                 rates[r], strobe_cnt - base, rx_if.o_rxByte, rx_if.o_errorFlag);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_glitch();
    test_framing_error();
    test_midframe_reset();
    test_back_to_back();
    test_baud_tolerance();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
